// File: rtl/job_manager_if.sv
// Scheduler-facing and host-facing handshake bundle for job_manager.
// The slave modport is the block itself; master is its environment.
interface job_manager_if #(
  parameter int unsigned CNT_W = 16
);
  logic             dsc_wr_valid_i;
  logic             dsc_wr_ready_o;
  logic [1023:0]    dsc_wr_data_i;
  logic             dsc0_ready_o;
  logic             dsc0_pull_i;
  logic [1023:0]    dsc0_data_o;
  logic             complete_push_i;
  logic [40:0]      return_data_i;
  logic             complete_ready_o;
  logic             cmpl_valid_o;
  logic [40:0]      cmpl_data_o;
  logic             cmpl_ready_i;
  logic [CNT_W-1:0] outstanding_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             overflow_o;
  logic             idle_o;

  modport slave (
    input  dsc_wr_valid_i, dsc_wr_data_i, dsc0_pull_i, complete_push_i, return_data_i,
           cmpl_ready_i,
    output dsc_wr_ready_o, dsc0_ready_o, dsc0_data_o, complete_ready_o, cmpl_valid_o,
           cmpl_data_o, outstanding_o, drop_cnt_o, overflow_o, idle_o
  );

  modport master (
    output dsc_wr_valid_i, dsc_wr_data_i, dsc0_pull_i, complete_push_i, return_data_i,
           cmpl_ready_i,
    input  dsc_wr_ready_o, dsc0_ready_o, dsc0_data_o, complete_ready_o, cmpl_valid_o,
           cmpl_data_o, outstanding_o, drop_cnt_o, overflow_o, idle_o
  );
endinterface

// File: rtl/job_manager.sv
// Descriptor FIFO feeding the scheduler, completion FIFO draining to the host writer,
// plus outstanding/drop accounting and a registered idle flag.
module job_manager #(
  parameter int unsigned DSC_DEPTH = 4,
  parameter int unsigned CMP_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  job_manager_if.slave  bus
);
  localparam int unsigned DscAw = $clog2(DSC_DEPTH);
  localparam int unsigned CmpAw = $clog2(CMP_DEPTH);
  localparam logic [DscAw:0]   DscOne = 1;
  localparam logic [CmpAw:0]   CmpOne = 1;
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Descriptor FIFO
  logic [1023:0]  dsc_mem [DSC_DEPTH];
  logic [DscAw:0] dsc_wr_ptr_q, dsc_rd_ptr_q;
  logic           dsc_full, dsc_empty, dsc_push, dsc_pop;

  assign dsc_full  = (dsc_wr_ptr_q[DscAw] != dsc_rd_ptr_q[DscAw]) &&
                     (dsc_wr_ptr_q[DscAw-1:0] == dsc_rd_ptr_q[DscAw-1:0]);
  assign dsc_empty = (dsc_wr_ptr_q == dsc_rd_ptr_q);
  assign dsc_push  = bus.dsc_wr_valid_i & ~dsc_full;
  assign dsc_pop   = bus.dsc0_pull_i & ~dsc_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsc_wr_ptr_q <= '0;
      dsc_rd_ptr_q <= '0;
    end else begin
      if (dsc_push) dsc_wr_ptr_q <= dsc_wr_ptr_q + DscOne;
      if (dsc_pop)  dsc_rd_ptr_q <= dsc_rd_ptr_q + DscOne;
    end
  end

  always_ff @(posedge clk) begin
    if (dsc_push) dsc_mem[dsc_wr_ptr_q[DscAw-1:0]] <= bus.dsc_wr_data_i;
  end

  assign bus.dsc_wr_ready_o = ~dsc_full;
  assign bus.dsc0_ready_o   = ~dsc_empty;
  assign bus.dsc0_data_o    = dsc_empty ? '0 : dsc_mem[dsc_rd_ptr_q[DscAw-1:0]];

  // Completion FIFO; the scheduler never waits, so a push at full is lost unless a
  // same-cycle pop frees the slot.
  logic [40:0]    cmp_mem [CMP_DEPTH];
  logic [CmpAw:0] cmp_wr_ptr_q, cmp_rd_ptr_q;
  logic           cmp_full, cmp_empty, cmp_push, cmp_pop, cmp_drop;

  assign cmp_full  = (cmp_wr_ptr_q[CmpAw] != cmp_rd_ptr_q[CmpAw]) &&
                     (cmp_wr_ptr_q[CmpAw-1:0] == cmp_rd_ptr_q[CmpAw-1:0]);
  assign cmp_empty = (cmp_wr_ptr_q == cmp_rd_ptr_q);
  assign cmp_pop   = bus.cmpl_ready_i & ~cmp_empty;
  assign cmp_push  = bus.complete_push_i & (~cmp_full | cmp_pop);
  assign cmp_drop  = bus.complete_push_i & cmp_full & ~cmp_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_wr_ptr_q <= '0;
      cmp_rd_ptr_q <= '0;
    end else begin
      if (cmp_push) cmp_wr_ptr_q <= cmp_wr_ptr_q + CmpOne;
      if (cmp_pop)  cmp_rd_ptr_q <= cmp_rd_ptr_q + CmpOne;
    end
  end

  always_ff @(posedge clk) begin
    if (cmp_push) cmp_mem[cmp_wr_ptr_q[CmpAw-1:0]] <= bus.return_data_i;
  end

  assign bus.complete_ready_o = ~cmp_full;
  assign bus.cmpl_valid_o     = ~cmp_empty;
  assign bus.cmpl_data_o      = cmp_empty ? '0 : cmp_mem[cmp_rd_ptr_q[CmpAw-1:0]];

  // Accounting
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             idle_q, idle_d;

  always_comb begin
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    overflow_d    = overflow_q | cmp_drop;
    // Every completion strobe retires a job, even one whose entry is dropped.
    case ({dsc_pop, bus.complete_push_i})
      2'b10: if (outstanding_q != CntMax) outstanding_d = outstanding_q + CntOne;
      2'b01: if (outstanding_q != '0)     outstanding_d = outstanding_q - CntOne;
      default: ;
    endcase
    if (cmp_drop && (drop_cnt_q != CntMax)) drop_cnt_d = drop_cnt_q + CntOne;
    idle_d = dsc_empty & cmp_empty & (outstanding_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      idle_q        <= idle_d;
    end
  end

  assign bus.outstanding_o = outstanding_q;
  assign bus.drop_cnt_o    = drop_cnt_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.idle_o        = idle_q;
endmodule

// File: tb/tb_job_manager.sv
// Directed bench for job_manager: expected descriptor and completion streams are queued
// at issue time and a negedge monitor checks every transfer the DUT presents.
module tb_job_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  job_manager_if #(.CNT_W(16)) bus ();

  job_manager #(
    .DSC_DEPTH(4),
    .CMP_DEPTH(16),
    .CNT_W    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [1023:0] exp_dsc[$];
  logic [40:0]   exp_cmp[$];

  function automatic logic [1023:0] mk_dsc(input logic [31:0] id);
    logic [1023:0] d;
    d = '0;
    d[1023:992] = id;
    d[511:480]  = ~id;
    d[8:0]      = id[8:0] + 9'd3;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dsc_wr_ready"},   64'(bus.dsc_wr_ready_o), 64'd1);
    chk({tag, "_dsc0_ready"},     64'(bus.dsc0_ready_o), 64'd0);
    chk({tag, "_dsc0_data_nz"},   64'(|bus.dsc0_data_o), 64'd0);
    chk({tag, "_complete_ready"}, 64'(bus.complete_ready_o), 64'd1);
    chk({tag, "_cmpl_valid"},     64'(bus.cmpl_valid_o), 64'd0);
    chk({tag, "_cmpl_data"},      64'(bus.cmpl_data_o), 64'd0);
    chk({tag, "_outstanding"},    64'(bus.outstanding_o), 64'd0);
    chk({tag, "_drop_cnt"},       64'(bus.drop_cnt_o), 64'd0);
    chk({tag, "_overflow"},       64'(bus.overflow_o), 64'd0);
    chk({tag, "_idle"},           64'(bus.idle_o), 64'd1);
  endtask

  // Scoreboard monitor: a transfer is committed at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dsc0_pull_i && bus.dsc0_ready_o) begin
        n_tests++;
        if (exp_dsc.size() == 0) begin
          n_fail++;
          $display("FAIL dsc_pull_unexpected: got id 0x%0h, expected no descriptor",
                   bus.dsc0_data_o[1023:992]);
        end else begin
          logic [1023:0] e;
          e = exp_dsc.pop_front();
          if (bus.dsc0_data_o !== e) begin
            n_fail++;
            $display("FAIL dsc_pull_data: got id 0x%0h pid 0x%0h, expected id 0x%0h pid 0x%0h",
                     bus.dsc0_data_o[1023:992], bus.dsc0_data_o[8:0], e[1023:992], e[8:0]);
          end
        end
      end
      if (bus.cmpl_valid_o && bus.cmpl_ready_i) begin
        n_tests++;
        if (exp_cmp.size() == 0) begin
          n_fail++;
          $display("FAIL cmpl_unexpected: got 0x%0h, expected no completion", bus.cmpl_data_o);
        end else begin
          logic [40:0] e;
          e = exp_cmp.pop_front();
          if (bus.cmpl_data_o !== e) begin
            n_fail++;
            $display("FAIL cmpl_data: got 0x%0h, expected 0x%0h", bus.cmpl_data_o, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion of the run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.dsc_wr_valid_i  = 1'b0;
    bus.dsc_wr_data_i   = '0;
    bus.dsc0_pull_i     = 1'b0;
    bus.complete_push_i = 1'b0;
    bus.return_data_i   = '0;
    bus.cmpl_ready_i    = 1'b0;

    repeat (2) cyc();
    chk_reset_vals("rst");
    rst = 1'b0;
    cyc();

    // Fill the descriptor FIFO.
    for (int i = 0; i < 4; i++) begin
      bus.dsc_wr_valid_i = 1'b1;
      bus.dsc_wr_data_i  = mk_dsc(32'h11 + 32'(i));
      cyc();
      if (i == 0) begin
        chk("dsc0_ready_after_1st", 64'(bus.dsc0_ready_o), 64'd1);
        chk("dsc0_head_id_0x11", 64'(bus.dsc0_data_o[1023:992]), 64'h11);
      end
    end
    bus.dsc_wr_valid_i = 1'b0;
    chk("dsc_wr_ready_full", 64'(bus.dsc_wr_ready_o), 64'd0);
    chk("dsc0_head_still_0x11", 64'(bus.dsc0_data_o[1023:992]), 64'h11);

    // Four spaced pulls, then one against an empty FIFO.
    for (int i = 0; i < 4; i++) begin
      exp_dsc.push_back(mk_dsc(32'h11 + 32'(i)));
      bus.dsc0_pull_i = 1'b1;
      cyc();
      bus.dsc0_pull_i = 1'b0;
      cyc();
    end
    chk("outstanding_4", 64'(bus.outstanding_o), 64'd4);
    chk("dsc0_ready_empty", 64'(bus.dsc0_ready_o), 64'd0);
    bus.dsc0_pull_i = 1'b1;
    cyc();
    bus.dsc0_pull_i = 1'b0;
    cyc();
    chk("outstanding_empty_pull", 64'(bus.outstanding_o), 64'd4);
    chk("dsc0_data_empty_zero", 64'(|bus.dsc0_data_o), 64'd0);

    // Simultaneous write and pull with one entry stored.
    bus.dsc_wr_valid_i = 1'b1;
    bus.dsc_wr_data_i  = mk_dsc(32'h21);
    cyc();
    bus.dsc_wr_data_i  = mk_dsc(32'h22);
    bus.dsc0_pull_i    = 1'b1;
    exp_dsc.push_back(mk_dsc(32'h21));
    cyc();
    bus.dsc_wr_valid_i = 1'b0;
    bus.dsc0_pull_i    = 1'b0;
    chk("wr_pull_ready", 64'(bus.dsc0_ready_o), 64'd1);
    chk("wr_pull_head_0x22", 64'(bus.dsc0_data_o[1023:992]), 64'h22);
    chk("wr_pull_outstanding", 64'(bus.outstanding_o), 64'd5);
    exp_dsc.push_back(mk_dsc(32'h22));
    bus.dsc0_pull_i = 1'b1;
    cyc();
    bus.dsc0_pull_i = 1'b0;
    cyc();
    chk("wr_pull_drained", 64'(bus.dsc0_ready_o), 64'd0);
    chk("outstanding_6", 64'(bus.outstanding_o), 64'd6);

    // 17 completions into a 16-deep FIFO with the writer stalled.
    for (int i = 1; i <= 17; i++) begin
      bus.complete_push_i = 1'b1;
      bus.return_data_i   = {9'(i - 1), 32'(i)};
      if (i <= 16) exp_cmp.push_back({9'(i - 1), 32'(i)});
      cyc();
    end
    bus.complete_push_i = 1'b0;
    chk("ovf_drop_cnt_1", 64'(bus.drop_cnt_o), 64'd1);
    chk("ovf_overflow_set", 64'(bus.overflow_o), 64'd1);
    chk("ovf_complete_ready_0", 64'(bus.complete_ready_o), 64'd0);
    chk("ovf_head_first", 64'(bus.cmpl_data_o), 64'h000_00000001);
    chk("ovf_outstanding_floor", 64'(bus.outstanding_o), 64'd0);
    bus.cmpl_ready_i = 1'b1;
    repeat (16) cyc();
    bus.cmpl_ready_i = 1'b0;
    chk("drain_valid_0", 64'(bus.cmpl_valid_o), 64'd0);
    chk("drain_overflow_sticky", 64'(bus.overflow_o), 64'd1);

    // Push at full with a same-cycle pop: accepted.
    for (int i = 0; i < 16; i++) begin
      bus.complete_push_i = 1'b1;
      bus.return_data_i   = {9'h1a5, 32'h100 + 32'(i)};
      exp_cmp.push_back({9'h1a5, 32'h100 + 32'(i)});
      cyc();
    end
    chk("full_again", 64'(bus.complete_ready_o), 64'd0);
    bus.return_data_i = {9'h0c3, 32'hcafe};
    bus.cmpl_ready_i  = 1'b1;
    exp_cmp.push_back({9'h0c3, 32'hcafe});
    cyc();
    bus.complete_push_i = 1'b0;
    chk("full_pop_no_drop", 64'(bus.drop_cnt_o), 64'd1);
    repeat (16) cyc();
    bus.cmpl_ready_i = 1'b0;
    chk("full_pop_drained", 64'(bus.cmpl_valid_o), 64'd0);

    // Three jobs round trip, then idle one cycle after the last drain.
    for (int i = 0; i < 3; i++) begin
      bus.dsc_wr_valid_i = 1'b1;
      bus.dsc_wr_data_i  = mk_dsc(32'h31 + 32'(i));
      cyc();
    end
    bus.dsc_wr_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_dsc.push_back(mk_dsc(32'h31 + 32'(i)));
      bus.dsc0_pull_i = 1'b1;
      cyc();
      bus.dsc0_pull_i = 1'b0;
      cyc();
    end
    chk("rt_outstanding_3", 64'(bus.outstanding_o), 64'd3);
    chk("rt_not_idle", 64'(bus.idle_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.complete_push_i = 1'b1;
      bus.return_data_i   = {9'(i + 7), 32'h31 + 32'(i)};
      exp_cmp.push_back({9'(i + 7), 32'h31 + 32'(i)});
      cyc();
    end
    bus.complete_push_i = 1'b0;
    chk("rt_outstanding_0", 64'(bus.outstanding_o), 64'd0);
    bus.cmpl_ready_i = 1'b1;
    repeat (3) cyc();
    bus.cmpl_ready_i = 1'b0;
    chk("rt_idle_lag", 64'(bus.idle_o), 64'd0);
    cyc();
    chk("rt_idle", 64'(bus.idle_o), 64'd1);

    // Asynchronous reset with traffic in flight.
    bus.complete_push_i = 1'b1;
    bus.return_data_i   = {9'h1, 32'h51};
    cyc();
    bus.return_data_i   = {9'h1, 32'h52};
    cyc();
    bus.complete_push_i = 1'b0;
    bus.dsc_wr_valid_i  = 1'b1;
    bus.dsc_wr_data_i   = mk_dsc(32'h41);
    cyc();
    bus.dsc_wr_data_i   = mk_dsc(32'h42);
    cyc();
    bus.dsc_wr_valid_i  = 1'b0;
    exp_dsc.push_back(mk_dsc(32'h41));
    bus.dsc0_pull_i = 1'b1;
    cyc();
    bus.dsc0_pull_i = 1'b0;
    chk("pre_rst_outstanding", 64'(bus.outstanding_o), 64'd1);
    chk("pre_rst_cmpl_valid", 64'(bus.cmpl_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    cyc();
    rst = 1'b0;
    cyc();
    chk_reset_vals("post_rst");

    chk("dsc_queue_empty", 64'(exp_dsc.size()), 64'd0);
    chk("cmp_queue_empty", 64'(exp_cmp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
